// File: rtl/cart_load_pkg.sv
// Shared definitions for the cartridge loader: loader FSM states,
// parameter defaults and the fixed widths of the download bus.
package cart_load_pkg;

   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_SLOTS      = 2;
   localparam int DEF_SKIP_DELAY = 5000000;
   localparam int DEF_SKIP_PULSE = 1000;

   localparam int IDX_W    = 8;
   localparam int IOADDR_W = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DELAY = 2'd2,
      ST_PULSE = 2'd3
   } state_t;

endpackage

// File: rtl/cart_mask_track.sv
// Per-slot ROM size mask: OR-accumulates the smeared write address so the
// mask ends up as the next power of two above the image size, minus one.
module cart_mask_track
   import cart_load_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              clr,
   input  logic              upd,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] mask
);

   logic [ADDR_W-1:0] smear;
   logic [ADDR_W-1:0] mask_reg;

   // Bit i is set when any address bit at or above i is set.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_smear
         assign smear[gi] = |addr[ADDR_W-1:gi];
      end
   endgenerate

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mask_reg <= '0;
      end else if (clr || upd) begin
         mask_reg <= (clr ? '0 : mask_reg) | (upd ? smear : '0);
      end
   end

   assign mask = mask_reg;

endmodule

// File: rtl/cart_load_ctrl.sv
// Cartridge download controller: routes ioctl bytes into per-slot ROM,
// tracks image size masks and sequences the optional skip-logo core reset.
module cart_load_ctrl
   import cart_load_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int SLOTS      = DEF_SLOTS,
   parameter int SKIP_DELAY = DEF_SKIP_DELAY,
   parameter int SKIP_PULSE = DEF_SKIP_PULSE,
   localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     ioctl_download,
   input  logic                     ioctl_wr,
   input  logic [IDX_W-1:0]         ioctl_index,
   input  logic [IOADDR_W-1:0]      ioctl_addr,
   input  logic [7:0]               ioctl_dout,
   input  logic                     skip_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_data,
   output logic [SLOT_W-1:0]        mem_slot,
   output logic [SLOTS*ADDR_W-1:0]  addr_mask,
   output logic [SLOTS-1:0]         slot_valid,
   output logic                     overflow,
   output logic                     core_reset,
   output logic                     busy
);

   localparam logic [31:0] DELAY_LAST = 32'(SKIP_DELAY - SKIP_PULSE - 1);
   localparam logic [31:0] PULSE_LAST = 32'(SKIP_PULSE - 1);

   state_t              state_reg, state_next;
   logic [31:0]         cnt_reg, cnt_next;
   logic                dl_prev_reg;
   logic [SLOT_W-1:0]   slot_reg;
   logic                slot_ok_reg;
   logic                any_acc_reg;
   logic                overflow_reg;
   logic [SLOTS-1:0]    valid_reg, valid_next;
   logic                mem_we_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [7:0]          mem_data_reg;
   logic [SLOT_W-1:0]   mem_slot_reg;

   logic                rise, fall, idx_ok, cur_ok, addr_hi_ok, accept, drop_ovf;
   logic [SLOT_W-1:0]   cur_slot;

   assign rise       = ioctl_download & ~dl_prev_reg;
   assign fall       = ~ioctl_download & dl_prev_reg;
   assign idx_ok     = {24'd0, ioctl_index} < 32'(SLOTS);
   // A write in the very cycle of the rising edge targets the slot being latched.
   assign cur_slot   = rise ? ioctl_index[SLOT_W-1:0] : slot_reg;
   assign cur_ok     = rise ? idx_ok : slot_ok_reg;
   assign addr_hi_ok = (ioctl_addr >> ADDR_W) == '0;
   assign accept     = ioctl_wr & ioctl_download & addr_hi_ok & cur_ok;
   assign drop_ovf   = ioctl_wr & ioctl_download & ~addr_hi_ok;

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         logic clr_slot, upd_slot;
         assign clr_slot = rise & idx_ok & (ioctl_index == 8'(gi));
         assign upd_slot = accept & (cur_slot == SLOT_W'(gi));
         cart_mask_track #(.ADDR_W(ADDR_W)) u_track (
            .clk_sys (clk_sys),
            .reset   (reset),
            .clr     (clr_slot),
            .upd     (upd_slot),
            .addr    (ioctl_addr[ADDR_W-1:0]),
            .mask    (addr_mask[gi*ADDR_W +: ADDR_W])
         );
      end
   endgenerate

   always_comb begin
      valid_next = valid_reg;
      for (int k = 0; k < SLOTS; k++) begin
         if (rise && idx_ok && ioctl_index == 8'(k))
            valid_next[k] = 1'b0;
         if (fall && slot_ok_reg && any_acc_reg && slot_reg == SLOT_W'(k))
            valid_next[k] = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rise) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (fall) begin
               cnt_next   = '0;
               state_next = (skip_en && slot_ok_reg && any_acc_reg) ? ST_DELAY : ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (rise) begin
               state_next = ST_LOAD;
               cnt_next   = '0;
            end else if (cnt_reg == DELAY_LAST) begin
               state_next = ST_PULSE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         ST_PULSE: begin
            if (rise) begin
               state_next = ST_LOAD;
               cnt_next   = '0;
            end else if (cnt_reg == PULSE_LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         dl_prev_reg  <= 1'b0;
         slot_reg     <= '0;
         slot_ok_reg  <= 1'b0;
         any_acc_reg  <= 1'b0;
         overflow_reg <= 1'b0;
         valid_reg    <= '0;
         mem_we_reg   <= 1'b0;
         mem_addr_reg <= '0;
         mem_data_reg <= '0;
         mem_slot_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         dl_prev_reg  <= ioctl_download;
         valid_reg    <= valid_next;
         any_acc_reg  <= (any_acc_reg & ~rise) | accept;
         overflow_reg <= (overflow_reg & ~rise) | drop_ovf;
         mem_we_reg   <= accept;
         if (rise) begin
            slot_reg    <= ioctl_index[SLOT_W-1:0];
            slot_ok_reg <= idx_ok;
         end
         if (accept) begin
            mem_addr_reg <= ioctl_addr[ADDR_W-1:0];
            mem_data_reg <= ioctl_dout;
            mem_slot_reg <= cur_slot;
         end
      end
   end

   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_data   = mem_data_reg;
   assign mem_slot   = mem_slot_reg;
   assign slot_valid = valid_reg;
   assign overflow   = overflow_reg;
   assign core_reset = reset | (state_reg == ST_LOAD) | (state_reg == ST_PULSE);
   assign busy       = state_reg != ST_IDLE;

endmodule
